// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//   Multi-cycle restoring-division sequencer for the DIV/MOD execution unit.
//   Each clock in CALC runs one N-bit subtractor trial: trial = rem - divisor.
//   The trial is accepted when there is no borrow. Quotient bits are produced
//   MSB first. A start/busy/done handshake connects the unit to the core
//   control unit.
//
//   Optional feature macro: DIV_SIGNED_EN (two's complement operands).
//     Undefined (default): unsigned-only divider. The N flag is tied to 0.
//     Defined: magnitudes are taken on the accepting edge, and the signs are
//              fixed up when the unit enters DONE.
//
//   Handshake:
//     - start is sampled only in IDLE. The edge that samples it is the
//       accepting edge. dividend and divisor are captured on that edge and
//       may change freely afterwards.
//     - busy is high in CALC and in DONE. Any start seen while busy is
//       ignored and is not queued.
//     - done pulses high for exactly one cycle (the DONE state).
//     - quotient, remainder and flags are valid from that cycle on. They
//       hold until the next DONE or until reset.
//
//   Ports:
//     clk          in   1   clock, rising edge
//     rst_n        in   1   synchronous active-low reset
//     start        in   1   operation request
//     dividend     in   N   numerator
//     divisor      in   N   denominator
//     busy         out  1   unit occupied (CALC or DONE)
//     done         out  1   one-cycle completion pulse
//     quotient     out  N   registered quotient
//     remainder    out  N   registered remainder
//     flags        out  4   {Z,N,C,V}, registered with the results
//     dbg_state_o  out  2   current FSM state (debug/observability)
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic [3:0]   flags,
  output logic [1:0]   dbg_state_o
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   rem_q, rem_d;     // partial remainder
  logic [N-1:0]   qacc_q, qacc_d;   // dividend shifting out, quotient shifting in
  logic [N-1:0]   dvs_q, dvs_d;     // latched divisor (magnitude in signed mode)
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   remo_q, remo_d;
  logic [3:0]     flags_q, flags_d;

  // One restoring step. The bit dropped from rem_q[N-1] is always 0: the
  // partial remainder before step i is below 2^(i-1).
  logic [N-1:0]   r_shift;
  logic [N:0]     trial;
  logic [N-1:0]   rem_next;
  logic [N-1:0]   qacc_next;
  logic [N-1:0]   q_fin;
  logic [N-1:0]   r_fin;
  logic           n_fin;
  logic           v_fin;

  assign r_shift   = {rem_q[N-2:0], qacc_q[N-1]};
  assign trial     = {1'b0, r_shift} - {1'b0, dvs_q};
  assign rem_next  = trial[N] ? r_shift : trial[N-1:0];
  assign qacc_next = {qacc_q[N-2:0], ~trial[N]};

`ifdef DIV_SIGNED_EN
  logic negq_q, negq_d;   // operand signs differ
  logic negr_q, negr_d;   // dividend negative
  logic ovf_q,  ovf_d;    // MIN / -1

  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    return v[N-1] ? ('0 - v) : v;
  endfunction

  assign q_fin = negq_q ? ('0 - qacc_next) : qacc_next;
  assign r_fin = negr_q ? ('0 - rem_next) : rem_next;
  assign n_fin = q_fin[N-1];
  assign v_fin = ovf_q;
`else
  assign q_fin = qacc_next;
  assign r_fin = rem_next;
  assign n_fin = 1'b0;
  assign v_fin = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    qacc_d  = qacc_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    flags_d = flags_q;
`ifdef DIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Divide by zero finishes on the accepting edge itself.
            state_d = S_DONE;
            quot_d  = '1;
            remo_d  = dividend;
`ifdef DIV_SIGNED_EN
            flags_d = 4'b0101;   // quotient all ones: N follows its MSB
`else
            flags_d = 4'b0001;
`endif
          end else begin
            state_d = S_CALC;
            count_d = CW'(N - 1);
            rem_d   = '0;
`ifdef DIV_SIGNED_EN
            qacc_d  = mag(dividend);
            dvs_d   = mag(divisor);
            negq_d  = dividend[N-1] ^ divisor[N-1];
            negr_d  = dividend[N-1];
            ovf_d   = (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
`else
            qacc_d  = dividend;
            dvs_d   = divisor;
`endif
          end
        end
      end
      S_CALC: begin
        rem_d  = rem_next;
        qacc_d = qacc_next;
        if (count_q == '0) begin
          // The last step's results are registered directly as outputs.
          state_d = S_DONE;
          quot_d  = q_fin;
          remo_d  = r_fin;
          flags_d = {(q_fin == '0), n_fin, (r_fin != '0), v_fin};
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      qacc_q  <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      flags_q <= 4'b0000;
`ifdef DIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      qacc_q  <= qacc_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      flags_q <= flags_d;
`ifdef DIV_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign flags       = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_seq_ctrl
//   Self-checking bench for div_seq_ctrl with N = 32.
//   The reference model works from plain '/' and '%' arithmetic.
//   Expected results are queued on the accepting edge and popped at done.
//   Inputs are driven #1 after a rising edge or on the falling edge.
//   Outputs are sampled #1 after a rising edge.
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

  localparam int N  = 32;
  localparam int RW = 2 * N + 4;   // {quotient, remainder, flags}

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic [3:0]   flags;
  logic [1:0]   dbg_state;

  logic [RW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;

  div_seq_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .flags       (flags),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] q, r;
    logic         z, n, c, v;
`ifdef DIV_SIGNED_EN
    if (b == 0) begin
      q = '1; r = a; v = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0; v = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      v = 1'b0;
    end
    n = q[N-1];
`else
    if (b == 0) begin
      q = '1; r = a; v = 1'b1;
    end else begin
      q = a / b; r = a % b; v = 1'b0;
    end
    n = 1'b0;
`endif
    z = (q == 0);
    c = (b != 0) && (r != 0);
    return {q, r, z, n, c, v};
  endfunction

  // ---------------- driver ----------------
  task automatic reset_dut(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, quotient, remainder, flags, dbg_state}, '0);
    rst_n = 1'b1;
  endtask

  // Wait until done is seen (#1 after an edge), bounded. Returns edges waited.
  task automatic wait_done(output int lat, output int busy_low);
    lat = 0;
    busy_low = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_low++;
    end
  endtask

  // One operation with an explicit expected result.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [RW-1:0] exp);
    int lat, busy_low;
    logic [RW-1:0] e;
    @(negedge clk);
    check("idle_before", {67'b0, busy}, '0);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);               // accepting edge
    exp_q.push_back(exp);
    #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    wait_done(lat, busy_low);
    check("latency", RW'(lat), RW'((b == 0) ? 0 : N));
    check("busy_during_op", RW'(busy_low), '0);
    e = exp_q.pop_front();
    check("result", {quotient, remainder, flags}, e);
    @(posedge clk); #1;
    check("done_one_cycle", {66'b0, done, busy}, '0);
    check("result_hold", {quotient, remainder, flags}, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, busy_low, t1, t2, seen;
    logic [N-1:0] a, b;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    reset_dut(3);

    // Directed cases
    run_op(32'd100, 32'd7, {32'd14, 32'd2, 4'b0010});
    run_op(32'd0,   32'd5, {32'd0,  32'd0, 4'b1000});
`ifdef DIV_SIGNED_EN
    run_op(32'd5, 32'd0, {32'hFFFF_FFFF, 32'd5, 4'b0101});
    run_op(32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b0110});
    run_op(32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0, 4'b0101});
`else
    run_op(32'd5, 32'd0, {32'hFFFF_FFFF, 32'd5, 4'b0001});
    run_op(32'hFFFF_FFFF, 32'h8000_0001, {32'd1, 32'h7FFF_FFFE, 4'b0010});
    run_op(32'hFFFF_FFFF, 32'd1, {32'hFFFF_FFFF, 32'd0, 4'b0000});
`endif

    // Back-to-back with start held: 9/3 then 10/4, done pulses 34 edges apart
    @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk);
    exp_q.push_back(model(32'd9, 32'd3));
    exp_q.push_back(model(32'd10, 32'd4));
    #1;
    dividend = 32'd10; divisor = 32'd4;
    wait_done(lat, busy_low);
    t1 = cyc;
    check("b2b_first", {quotient, remainder, flags}, exp_q.pop_front());
    check("b2b_first_val", {quotient, remainder}, {32'd3, 32'd0});
    @(posedge clk); #1;           // DONE -> IDLE
    @(posedge clk); #1;           // second accepting edge
    start = 1'b0;
    wait_done(lat, busy_low);
    t2 = cyc;
    check("b2b_spacing", RW'(t2 - t1), RW'(34));
    check("b2b_second", {quotient, remainder}, {32'd2, 32'd2});
    check("b2b_second_model", {quotient, remainder, flags}, exp_q.pop_front());
    @(posedge clk); #1;

    // Start ignored mid-CALC, then reset abandons the operation
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'd50; divisor = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_ignored_start", {67'b0, busy}, {67'b0, 1'b1});
    check("no_done_from_ignored_start", {67'b0, done}, '0);
    repeat (9) @(posedge clk);
    reset_dut(1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("no_done_after_reset", RW'(seen), '0);

    // Randomized operations against the model
    repeat (40) begin
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'h8000_0000 | $urandom;
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom;
      run_op(a, b, model(a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
